// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: operand widths and prefetch fill states.
// Imported by the prefetch queue and its byte storage.
package cpu_pkg;

  localparam int OPE_W         = 32;
  localparam int BYTE_W        = 8;
  localparam int MAX_OPE_BYTES = 4;

  typedef enum logic [1:0] {
    PQ_IDLE    = 2'd0,
    PQ_WAIT    = 2'd1,
    PQ_DISCARD = 2'd2
  } pq_state_e;

endpackage

// File: rtl/pq_byte_ram.sv
// Circular DEPTH x 8 byte store: up to 4 enabled byte writes at wr_ptr_i,
// 4-byte combinational read window at rd_ptr_i (lane 0 = [31:24]).
module pq_byte_ram
  import cpu_pkg::*;
#(
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned PW    = $clog2(DEPTH)
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [MAX_OPE_BYTES-1:0] we_i,
  input  logic [PW-1:0]            wr_ptr_i,
  input  logic [OPE_W-1:0]         wdata_i,
  input  logic [PW-1:0]            rd_ptr_i,
  output logic [OPE_W-1:0]         rdata_o
);

  logic [BYTE_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < int'(DEPTH); i++)
        mem_q[i] <= '0;
    end else begin
      for (int k = 0; k < MAX_OPE_BYTES; k++)
        if (we_i[k])
          mem_q[wr_ptr_i + PW'(k)] <=
            wdata_i[OPE_W-1-BYTE_W*k -: BYTE_W];
    end
  end

  always_comb begin
    rdata_o = '0;
    for (int k = 0; k < MAX_OPE_BYTES; k++)
      rdata_o[OPE_W-1-BYTE_W*k -: BYTE_W] =
        mem_q[rd_ptr_i + PW'(k)];
  end

endmodule

// File: rtl/prefetch_queue.sv
// Byte-granular instruction prefetch queue: fetches aligned words, presents
// a 4-byte opcode window at ope_eip, consumes 1..4 bytes, redirects on flush.
module prefetch_queue
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH     = 16,
  parameter logic [31:0] RESET_EIP = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     mem_req,
  output logic [31:0]              mem_addr,
  input  logic [31:0]              mem_rdata,
  input  logic                     mem_valid,
  input  logic                     flush,
  input  logic [31:0]              flush_eip,
  input  logic                     consume,
  input  logic [3:0]               consume_len,
  output logic [OPE_W-1:0]         ope,
  output logic                     ope_valid,
  output logic [31:0]              ope_eip,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     consume_err
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;

  pq_state_e   state_q, state_d;
  logic [31:0] fetch_addr_q, fetch_addr_d;
  logic [1:0]  drop_q, drop_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [31:0] eip_q, eip_d;
  logic        mem_req_q, mem_req_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic        err_q, err_d;

  logic [MAX_OPE_BYTES-1:0] we;
  logic [OPE_W-1:0] wdata, win;
  logic          len_ok, cons_ok, push;
  logic [LW-1:0] free, push_n, cons_n;

  assign free      = LW'(DEPTH) - level_q;
  assign ope_valid = level_q >= LW'(MAX_OPE_BYTES);
  assign len_ok    = consume_len != 4'd0 && consume_len <= 4'd4;
  assign cons_ok   = consume && ope_valid && len_ok;
  assign push      = state_q == PQ_WAIT && mem_valid && !flush;
  assign push_n    = LW'(MAX_OPE_BYTES) - LW'(drop_q);
  assign cons_n    = cons_ok ? LW'(consume_len) : '0;

  // Skipped leading bytes are shifted out so the kept ones land on lane 0.
  assign wdata = mem_rdata << {drop_q, 3'b000};
  assign we    = push ? (4'b1111 >> drop_q) : 4'b0000;

  pq_byte_ram #(.DEPTH(DEPTH)) u_ram (
    .clk_i    (clk),
    .reset_i  (reset),
    .we_i     (we),
    .wr_ptr_i (wr_ptr_q),
    .wdata_i  (wdata),
    .rd_ptr_i (rd_ptr_q),
    .rdata_o  (win)
  );

  // Bytes past the fill level are masked so stale storage never shows.
  always_comb begin
    ope = '0;
    for (int k = 0; k < MAX_OPE_BYTES; k++)
      if (level_q > LW'(k))
        ope[OPE_W-1-BYTE_W*k -: BYTE_W] =
          win[OPE_W-1-BYTE_W*k -: BYTE_W];
  end

  assign ope_eip     = eip_q;
  assign level       = level_q;
  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign consume_err = err_q;

  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    drop_d       = drop_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    level_d      = level_q;
    eip_d        = eip_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    err_d        = err_q;

    if (flush) begin
      level_d      = '0;
      rd_ptr_d     = '0;
      wr_ptr_d     = '0;
      eip_d        = flush_eip;
      fetch_addr_d = {flush_eip[31:2], 2'b00};
      drop_d       = flush_eip[1:0];
    end else begin
      if (consume && !cons_ok)
        err_d = 1'b1;
      if (cons_ok) begin
        rd_ptr_d = rd_ptr_q + PW'(consume_len);
        eip_d    = eip_q + 32'(consume_len);
      end
      level_d = level_q + (push ? push_n : '0) - cons_n;
      if (push) begin
        wr_ptr_d     = wr_ptr_q + PW'(push_n);
        drop_d       = 2'd0;
        fetch_addr_d = fetch_addr_q + 32'd4;
      end
    end

    unique case (state_q)
      PQ_IDLE: begin
        if (!flush && free >= LW'(MAX_OPE_BYTES)) begin
          state_d    = PQ_WAIT;
          mem_req_d  = 1'b1;
          mem_addr_d = fetch_addr_q;
        end
      end
      PQ_WAIT: begin
        // A word returning in the flush cycle completes the request but
        // is thrown away, so no discard state is needed then.
        if (mem_valid) begin
          state_d   = PQ_IDLE;
          mem_req_d = 1'b0;
        end else if (flush) begin
          state_d = PQ_DISCARD;
        end
      end
      PQ_DISCARD: begin
        if (mem_valid) begin
          state_d   = PQ_IDLE;
          mem_req_d = 1'b0;
        end
      end
      default: begin
        state_d   = PQ_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= PQ_IDLE;
      fetch_addr_q <= {RESET_EIP[31:2], 2'b00};
      drop_q       <= RESET_EIP[1:0];
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      level_q      <= '0;
      eip_q        <= RESET_EIP;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      drop_q       <= drop_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      level_q      <= level_d;
      eip_q        <= eip_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      err_q        <= err_d;
    end
  end

endmodule

// File: doc/prefetch_queue.md
Name: prefetch_queue

Overview:
- Byte-granular instruction prefetch buffer between instruction memory and decode. It replaces the single-word fetch latch.
- Fetches aligned 32-bit words ahead of execution and queues them as bytes.
- Presents a 4-byte opcode window starting at the current instruction boundary to decode.
- Decode consumes a variable 1..4 bytes per instruction (num_of_ope). A flush redirects fetch for jumps, calls and returns.

Parameters:
- DEPTH, 16, queue capacity in bytes; power of 2, at least 8.
- RESET_EIP, 32'h0000_0000, fetch start address after reset.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- reset  in  1  synchronous, active-high.
- mem_req  out  1  word fetch request, held until mem_valid.
- mem_addr  out  32  word-aligned fetch address; bits [1:0] are always 0.
- mem_rdata  in  32  fetched word; byte at mem_addr is in [31:24], mem_addr+3 is in [7:0].
- mem_valid  in  1  mem_rdata is valid; completes the outstanding request.
- flush  in  1  discard all queued and in-flight bytes and restart fetch.
- flush_eip  in  32  new instruction address; may be unaligned.
- consume  in  1  decode accepts the current instruction.
- consume_len  in  4  bytes consumed: 1..4.
- ope  out  32  byte at ope_eip in [31:24], followed by the next 3 bytes.
- ope_valid  out  1  at least 4 bytes are queued.
- ope_eip  out  32  address of ope[31:24].
- level  out  $clog2(DEPTH)+1  number of queued bytes.
- consume_err  out  1  sticky error flag; cleared only by reset.

Behaviour:
- Reset values:
  - level=0, rd_ptr=wr_ptr=0, storage cleared.
  - ope=0, ope_valid=0, ope_eip=RESET_EIP, mem_req=0, consume_err=0.
  - fetch_addr={RESET_EIP[31:2],2'b00}, drop=RESET_EIP[1:0].
  - State IDLE.
- Reset mid-request abandons the request; a mem_valid arriving after reset in IDLE is ignored.
- Fill FSM states IDLE, WAIT, DISCARD:
  - IDLE to WAIT when free space (DEPTH-level) >= 4 and flush=0. mem_req=1 and mem_addr=fetch_addr are registered, so they are visible the cycle after the decision.
  - WAIT with mem_valid: push the bytes of mem_rdata, skipping the first `drop` bytes. Then drop=0, fetch_addr+=4, mem_req=0, go to IDLE.
  - WAIT with flush: go to DISCARD with mem_req still 1.
  - DISCARD with mem_valid: drop the data, set mem_req=0, go to IDLE.
- Only one request is outstanding; memory latency is at least 1 cycle.
- Word push writes 4-drop bytes at wr_ptr, then wr_ptr wraps modulo DEPTH.
- Output latency:
  - Bytes pushed at edge N are reflected in level and ope from cycle N+1.
  - ope, ope_valid and ope_eip are combinational from registered state.
- Consume, only when ope_valid=1 and consume_len is in 1..4:
  - rd_ptr+=consume_len (mod DEPTH).
  - ope_eip+=consume_len.
  - level-=consume_len.
- Invalid consume:
  - consume=1 with ope_valid=0 is ignored and sets consume_err.
  - consume_len of 0 or greater than 4 is ignored and sets consume_err.
- Push and consume in the same cycle: level = level + pushed - consumed.
- Full: with free space below 4, no request is issued; the queue never overflows.
- Window wrap: ope bytes index (rd_ptr+i) mod DEPTH, with no gap at wrap-around.
- Flush has priority over consume and mem_valid in that cycle. It sets:
  - level=0, rd_ptr=wr_ptr=0.
  - ope_eip=flush_eip.
  - fetch_addr={flush_eip[31:2],2'b00}, drop=flush_eip[1:0].
- Queue arithmetic: all widths are exact; ope_eip and fetch_addr wrap modulo 2^32.

Decomposition:
- Shared package cpu_pkg holds:
  - OPE_W=32, BYTE_W=8, MAX_OPE_BYTES=4.
  - Fill-state encodings PQ_IDLE=2'd0, PQ_WAIT=2'd1, PQ_DISCARD=2'd2.
- One natural sub-module, pq_byte_ram: DEPTH x 8 circular storage.
  - Write: up to 4 bytes at wr_ptr with a per-byte enable.
  - Read: 4-byte combinational window at rd_ptr.
  - Pointer and level arithmetic stays in prefetch_queue.

Test Plan:
1. Reset, then memory returns 32'h5589E5B8 at addr 0 with 1-cycle latency:
   - mem_addr=0 is seen first, then mem_addr=4.
   - The cycle after the first mem_valid: ope=5589E5B8, ope_valid=1, ope_eip=0, level=4.
2. Variable consume:
   - Setup: words 5589E5B8 and 02000000 at addr 0 and 4.
   - consume_len=1 gives ope=89E5B802, ope_eip=1.
   - consume_len=2 gives ope=B8020000, ope_eip=3.
3. Unaligned flush:
   - Stimulus: flush with flush_eip=0x0000_0006, memory word at 4 = AABBCCDD, word at 8 = 11223344.
   - mem_addr=4 is requested first; 2 bytes are dropped.
   - Result: ope=CCDD1122, ope_eip=6.
4. Flush in WAIT:
   - Stimulus: flush asserted while a request to addr 8 is outstanding.
   - The returning word is discarded, then mem_addr=flush target is requested.
   - No stale byte appears in ope.
5. Fill to full with no consume, DEPTH=16:
   - level reaches 16 after 4 words; mem_req stays 0.
   - consume_len=4 releases the next request.
   - Drain across wrap-around and compare ope against a byte model.
6. Error cases:
   - consume with ope_valid=0 leaves ope_eip unchanged and sets consume_err=1.
   - consume_len=5 is ignored.
   - A later reset clears consume_err.
